dmem_lsu_ctrl: RTL and testbench

- Load/store sequencer between the core's memory stage and the word-addressed data memory.
- Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word reads and writes.
- Performs byte-lane extraction and sign/zero extension on loads, and read-modify-write on sub-word stores.
- Flags misaligned and out-of-range accesses without touching memory.

---
 rtl/dmem_lsu_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_lsu_ctrl : byte-addressed RV32I load/store sequencer in front of a
//                 word-addressed data memory (lane select, extend, sub-word RMW).
// Optional build macro: DMEM_LSU_MMIO_EN (read-only ID words at 0x00100000/4).
// Revision: 1.0
// ============================================================================
module dmem_lsu_ctrl #(
   parameter int          DMEM_SIZE = 4096,
   parameter logic [31:0] MMIO_ID0  = 32'h00000000,
   parameter logic [31:0] MMIO_ID1  = 32'h16726992
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [31:0] C_DMEM_BYTES = 32'(DMEM_SIZE);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LD     = 3'd1,
      S_WR     = 3'd2,
      S_RMW_RD = 3'd3,
      S_RMW_WR = 3'd4,
      S_ERR    = 3'd5,
      S_RESP   = 3'd6
   } state_t;

   state_t      r_state;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [1:0]  r_ofs;
   logic [15:0] r_wdata;
   logic        r_mmio;
   logic        r_mmio_hi;

   logic w_misal;
   logic w_oor;
   logic w_illegal;
   logic w_err;
   logic w_mmio_hit;

   always_comb begin
      w_mmio_hit = 1'b0;
`ifdef DMEM_LSU_MMIO_EN
      w_mmio_hit = (req_addr[31:3] == 29'h0002_0000);
`endif
      case (req_funct3)
         3'b001, 3'b101: w_misal = req_addr[0];
         3'b010:         w_misal = |req_addr[1:0];
         default:        w_misal = 1'b0;
      endcase
      w_oor = (req_addr >= C_DMEM_BYTES) && !w_mmio_hit;
      if (req_we)
         w_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
      else
         w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
      w_err = w_misal || w_oor || w_illegal;
   end

   function automatic logic [31:0] load_ext(input logic [31:0] word,
                                            input logic [1:0]  ofs,
                                            input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{ofs, 3'b000} +: 8];
      h = ofs[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h000000, b};
         3'b101:  return {16'h0000, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old,
                                               input logic [15:0] wd,
                                               input logic [1:0]  ofs,
                                               input logic [2:0]  f3);
      logic [31:0] m;
      m = old;
      if (f3[1:0] == 2'b00)
         m[{ofs, 3'b000} +: 8] = wd[7:0];
      else
         m[{ofs[1], 4'b0000} +: 16] = wd;
      return m;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= 32'h0;
         mem_wdata  <= 32'h0;
         r_we       <= 1'b0;
         r_funct3   <= 3'b000;
         r_ofs      <= 2'b00;
         r_wdata    <= 16'h0;
         r_mmio     <= 1'b0;
         r_mmio_hi  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we      <= req_we;
                  r_funct3  <= req_funct3;
                  r_ofs     <= req_addr[1:0];
                  r_wdata   <= req_wdata[15:0];
                  r_mmio    <= w_mmio_hit;
                  r_mmio_hi <= req_addr[2];
                  mem_addr  <= {2'b00, req_addr[31:2]};
                  req_ready <= 1'b0;
                  if (w_err) begin
                     r_state <= S_ERR;
                  end else if (w_mmio_hit) begin
                     // ID words are served with load timing but never touch memory
                     r_state <= S_LD;
                  end else if (!req_we) begin
                     r_state  <= S_LD;
                     mem_read <= 1'b1;
                  end else if (req_funct3[1:0] == 2'b10) begin
                     r_state   <= S_WR;
                     mem_write <= 1'b1;
                     mem_wdata <= req_wdata;
                  end else begin
                     r_state  <= S_RMW_RD;
                     mem_read <= 1'b1;
                  end
               end
            end
            S_LD: begin
               mem_read   <= 1'b0;
               resp_valid <= 1'b1;
               resp_rdata <= r_we ? 32'h0 :
                             load_ext(r_mmio ? (r_mmio_hi ? MMIO_ID1 : MMIO_ID0) : mem_rdata,
                                      r_ofs, r_funct3);
               r_state    <= S_RESP;
            end
            S_WR: begin
               mem_write  <= 1'b0;
               resp_valid <= 1'b1;
               r_state    <= S_RESP;
            end
            S_RMW_RD: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b1;
               mem_wdata <= store_merge(mem_rdata, r_wdata, r_ofs, r_funct3);
               r_state   <= S_RMW_WR;
            end
            S_RMW_WR: begin
               mem_write  <= 1'b0;
               resp_valid <= 1'b1;
               r_state    <= S_RESP;
            end
            S_ERR: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b1;
               r_state    <= S_RESP;
            end
            S_RESP: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= 32'h0;
               req_ready  <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state   <= S_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dmem_lsu_ctrl : randomized bench for dmem_lsu_ctrl against a byte-level
//                    reference model of the memory and access rules.
// Revision: 1.0
// ============================================================================
module tb_dmem_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] dmem    [0:1023];
   logic [31:0] ref_mem [0:1023];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_lsu_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   assign mem_rdata = (mem_addr < 32'd1024) ? dmem[mem_addr[9:0]] : 32'h0;

   always @(posedge clk)
      if (mem_write && mem_addr < 32'd1024)
         dmem[mem_addr[9:0]] <= mem_wdata;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: computes the architectural result from the access rules and
   // updates the reference memory for successful stores.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                        output int lat, output int nrd, output int nwr);
      int          width;
      logic        illegal, mmio;
      logic [31:0] word, v, mask, sh;
      illegal = we ? !(f3 == 0 || f3 == 1 || f3 == 2) : (f3 == 3 || f3 == 6 || f3 == 7);
      width   = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      mmio    = 1'b0;
`ifdef DMEM_LSU_MMIO_EN
      mmio    = (a >= 32'h0010_0000) && (a < 32'h0010_0008);
`endif
      err   = illegal || (a % width != 0) || (a >= 32'd4096 && !mmio);
      rdata = 32'h0;
      lat   = 2;
      nrd   = 0;
      nwr   = 0;
      if (err) return;
      sh = (a % 4) * 8;
      if (mmio) begin
         word = (a >= 32'h0010_0004) ? 32'h16726992 : 32'h00000000;
      end else begin
         word = ref_mem[a / 4];
      end
      if (!we) begin
         if (!mmio) nrd = 1;
         v = word >> sh;
         if (width == 1) begin
            v = v % 256;
            if (f3 == 0 && v >= 128) v = v + 32'hFFFF_FF00;
         end else if (width == 2) begin
            v = v % 65536;
            if (f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000;
         end
         rdata = v;
      end else if (!mmio) begin
         if (width == 4) begin
            nwr = 1;
            ref_mem[a / 4] = wd;
         end else begin
            lat  = 3;
            nrd  = 1;
            nwr  = 1;
            mask = ((32'd1 << (8 * width)) - 1) << sh;
            ref_mem[a / 4] = (word & ~mask) | ((wd << sh) & mask);
         end
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] got_rdata,
                         output logic got_err);
      logic        e_err;
      logic [31:0] e_rdata;
      int          e_lat, e_nrd, e_nwr;
      int          lat, nrd, nwr, rdc, wrc, ovl, abad;
      bit          done;
      model(we, f3, a, wd, e_err, e_rdata, e_lat, e_nrd, e_nwr);
      @(negedge clk);
      check_val("ready_idle", {31'b0, req_ready}, 32'd1);
      check_val("single_pulse", {31'b0, resp_valid}, 32'd0);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      lat = 0; nrd = 0; nwr = 0; rdc = 0; wrc = 0; ovl = 0; abad = 0; done = 1'b0;
      while (!done && lat < 10) begin
         @(negedge clk);
         lat++;
         if (mem_read && mem_write) ovl++;
         if ((mem_read || mem_write) && mem_addr != (a >> 2)) abad++;
         if (mem_read)  begin nrd++; if (rdc == 0) rdc = lat; end
         if (mem_write) begin nwr++; if (wrc == 0) wrc = lat; end
         if (resp_valid) done = 1'b1;
      end
      got_rdata = resp_rdata;
      got_err   = resp_err;
      if (!done) begin
         check_val("resp_timeout", 32'd0, 32'd1);
         return;
      end
      check_val("latency",   lat, e_lat);
      check_val("resp_err",  {31'b0, resp_err}, {31'b0, e_err});
      check_val("resp_rdata", resp_rdata, e_rdata);
      check_val("n_reads",   nrd, e_nrd);
      check_val("n_writes",  nwr, e_nwr);
      check_val("read_cyc",  rdc, (e_nrd != 0) ? 1 : 0);
      check_val("write_cyc", wrc, (e_nwr != 0) ? ((e_nrd != 0) ? 2 : 1) : 0);
      check_val("rd_wr_overlap", ovl, 0);
      check_val("strobe_addr", abad, 0);
   endtask

   logic [31:0] r;
   logic        e;
   logic [31:0] a;
   int          bad;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         dmem[i]    = $urandom;
         ref_mem[i] = dmem[i];
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_ready",  {31'b0, req_ready},  32'd1);
      check_val("rst_rvalid", {31'b0, resp_valid}, 32'd0);
      check_val("rst_err",    {31'b0, resp_err},   32'd0);
      check_val("rst_rdata",  resp_rdata, 32'h0);
      check_val("rst_mrd",    {31'b0, mem_read},   32'd0);
      check_val("rst_mwr",    {31'b0, mem_write},  32'd0);
      check_val("rst_maddr",  mem_addr,  32'h0);
      check_val("rst_mwdata", mem_wdata, 32'h0);
      rst = 1'b0;

      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r, e);
      check_val("sw_err", {31'b0, e}, 32'd0);
      do_req(1'b0, 3'b000, 32'h13, 32'h0, r, e); check_val("lb_13",  r, 32'hFFFFFFDE);
      do_req(1'b0, 3'b100, 32'h13, 32'h0, r, e); check_val("lbu_13", r, 32'h000000DE);
      do_req(1'b0, 3'b001, 32'h12, 32'h0, r, e); check_val("lh_12",  r, 32'hFFFFDEAD);
      do_req(1'b0, 3'b101, 32'h12, 32'h0, r, e); check_val("lhu_12", r, 32'h0000DEAD);
      do_req(1'b1, 3'b000, 32'h11, 32'h55, r, e);
      do_req(1'b1, 3'b001, 32'h12, 32'h1234, r, e);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, r, e); check_val("rmw_final", r, 32'h123455EF);
      do_req(1'b0, 3'b010, 32'h02, 32'h0, r, e);   check_val("lw_misal", {31'b0, e}, 32'd1);
      do_req(1'b1, 3'b001, 32'h01, 32'h0, r, e);   check_val("sh_misal", {31'b0, e}, 32'd1);
      do_req(1'b0, 3'b010, 32'h1000, 32'h0, r, e); check_val("lw_oor",   {31'b0, e}, 32'd1);
      do_req(1'b0, 3'b010, 32'h00100004, 32'h0, r, e);
`ifdef DMEM_LSU_MMIO_EN
      check_val("mmio_id1", r, 32'h16726992);
`else
      check_val("mmio_off_err", {31'b0, e}, 32'd1);
`endif

      // Reset while an SB sits in its write cycle
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h21; req_wdata = 32'hAA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("rmw_wr_before_rst", {31'b0, mem_write}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check_val("rst_async_mwr",   {31'b0, mem_write},  32'd0);
      check_val("rst_async_ready", {31'b0, req_ready},  32'd1);
      check_val("rst_async_rv",    {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid || mem_write || mem_read || !req_ready) bad++;
      end
      check_val("post_rst_quiet", bad, 0);
      check_val("rst_word_kept", dmem[8], ref_mem[8]);

      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0:       a = 32'h0000_0FF8 + $urandom_range(0, 15);
            1:       a = 32'h0010_0000 + $urandom_range(0, 7);
            2:       a = $urandom;
            default: a = $urandom_range(0, 4095);
         endcase
         if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
         do_req(1'($urandom), 3'($urandom), a, $urandom, r, e);
      end

      bad = 0;
      for (int i = 0; i < 1024; i++)
         if (dmem[i] !== ref_mem[i]) bad++;
      check_val("mem_image", bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
